if_id_buffer: RTL and testbench
===============================

// Module: if_id_buffer
// PURPOSE
//  Decoupling buffer between the instruction-fetch stage and the decode stage of the RV32IM pipeline.
//  Captures {instr, pc, pc+4} from fetch under a valid/ready handshake and holds up to DEPTH entries in a FIFO.
//  Presents the oldest entry to decode. Decode-side backpressure therefore stalls fetch without losing instructions.
//  A flush discards every buffered instruction on a branch/JAL/JALR redirect.
// PARAMETERS
//  DEPTH    2             number of entries; power of two, >= 2
//  NOP_INSN 32'h00000013  value driven on out_instr when empty (addi x0,x0,0)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   fetch presents a valid instruction
//  in_ready   out  1   buffer can accept this cycle
//  in_instr   in   32  fetched instruction word
//  in_pc      in   32  address of in_instr (fetch curr_addr)
//  in_pc4     in   32  in_pc + 4 (fetch next_addr)
//  flush      in   1   redirect: discard all entries
//  out_valid  out  1   head entry valid for decode
//  out_ready  in   1   decode consumes the head this cycle
//  out_instr  out  32  head instruction, NOP_INSN when empty
//  out_pc     out  32  head pc, 0 when empty
//  out_pc4    out  32  head pc+4, 0 when empty
//  count      out  $clog2(DEPTH+1)  entries held
// BEHAVIOUR
//  - Reset (async, rst=1): wr_ptr=rd_ptr=count=0, so in_ready=1, out_valid=0, out_instr=NOP_INSN, out_pc=out_pc4=0.
//    Storage contents are don't-care.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, 0..DEPTH.
//  - in_ready = (count != DEPTH). This is combinational from state only; it never depends on out_ready.
//  - out_valid = (count != 0). Outputs come from the storage entry at rd_ptr. There is no in->out bypass.
//  - push = in_valid & in_ready & ~flush.  pop = out_valid & out_ready & ~flush.
//  - Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1. Minimum latency is 1 cycle.
//  - push & pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count.
//  - Full (count=DEPTH): in_ready=0 and in_valid is ignored, even if pop is active. Fetch must hold its data.
//  - Empty: out_ready is ignored and count stays 0. It never underflows.
//  - flush=1 at an edge: wr_ptr=rd_ptr=count=0. Any concurrent push/pop is cancelled, and flush wins over everything.
//    The instruction presented in the flush cycle is dropped.
//  - The cycle after a flush is an empty buffer: in_ready=1, out_valid=0.
//  - Reset asserted mid-operation clears state immediately, regardless of handshakes in flight.
//  - Data fields are stored verbatim. There is no arithmetic on pc: pc4 is taken from fetch, not recomputed.
// CONFIGURATION
//  IF_ID_PREDECODE_EN defined:
//   - Adds outputs out_is_branch, out_is_jal, out_is_jalr (1 bit each).
//   - These decode opcode[6:0] = 1100011, 1101111, 1100111 respectively. They are computed at push time and stored
//     per entry (3 extra bits per entry).
//   - All three are 0 on reset and when empty.
//  IF_ID_PREDECODE_EN not defined: these ports and the storage do not exist. All other behaviour is identical.
// TESTING
//  1. Reset: rst=1 with in_valid=1 -> in_ready=1, out_valid=0, out_instr=32'h00000013, count=0.
//     Release rst: still empty.
//  2. Single pass: push {instr=32'h00500093, pc=0, pc4=4} with out_ready=1 -> next cycle out_valid=1, out_instr=32'h00500093,
//     out_pc4=4. The cycle after, count=0.
//  3. Backpressure: out_ready=0, push pc=0,4,8 on consecutive cycles -> count=2, in_ready=0 after the 2nd push,
//     and the pc=8 entry is not accepted. Then out_ready=1 -> outputs pc 0 then pc 4 in order, and in_ready returns to 1.
//  4. Streaming: count=1, then 10 cycles of in_valid=1 and out_ready=1 -> count stays 1.
//     out_pc sequence is in_pc delayed by the buffered depth, with no gaps. Continue past 4 entries to exercise pointer wrap.
//  5. Flush: count=2, assert flush with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0.
//     Then push pc=32'h40 -> that entry appears; the discarded entries never reappear.
//  6. Async reset mid-stream: count=2, pulse rst between edges -> out_valid drops to 0 immediately, without waiting for clk.
//     With IF_ID_PREDECODE_EN: pushing 32'h0000006F yields out_is_jal=1, and the other two flags are 0.

Source files
------------

// File: rtl/if_id_if.sv
// if_id_if: fetch/decode handshake bundle for the IF/ID decoupling buffer
// Parameter DEPTH sizes count; must match the buffer's DEPTH.
// master: fetch + decode side (drives in_*, flush, out_ready)
// slave : buffer side (drives in_ready, out_*, count)
// IF_ID_PREDECODE_EN adds out_is_branch/out_is_jal/out_is_jalr.
interface if_id_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic [31:0]   in_pc4;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc4;
    logic [CW-1:0] count;
`ifdef IF_ID_PREDECODE_EN
    logic          out_is_branch;
    logic          out_is_jal;
    logic          out_is_jalr;
    modport master (
        output in_valid, in_instr, in_pc, in_pc4, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_pc4, count,
               out_is_branch, out_is_jal, out_is_jalr
    );
    modport slave (
        input  in_valid, in_instr, in_pc, in_pc4, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_pc4, count,
               out_is_branch, out_is_jal, out_is_jalr
    );
`else
    modport master (
        output in_valid, in_instr, in_pc, in_pc4, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_pc4, count
    );
    modport slave (
        input  in_valid, in_instr, in_pc, in_pc4, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_pc4, count
    );
`endif
endinterface

// File: rtl/if_id_buffer.sv
// if_id_buffer: DEPTH-entry FIFO decoupling RV32IM fetch from decode
// Ports: clk, rst (async, active-high), bus (if_id_if.slave):
//   in_valid/in_ready/in_instr/in_pc/in_pc4 from fetch, flush redirect,
//   out_valid/out_ready/out_instr/out_pc/out_pc4 to decode, count = entries held.
// Empty outputs: out_instr=NOP_INSN, out_pc=out_pc4=0.
// IF_ID_PREDECODE_EN adds per-entry branch/jal/jalr flags decoded at push time.
module if_id_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input logic    clk,
    input logic    rst,
    if_id_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   pc4_q   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          push, pop;
    assign bus.in_ready  = cnt != CW'(DEPTH);
    assign bus.out_valid = cnt != '0;
    assign bus.count     = cnt;
    // flush cancels any handshake completing in the same cycle
    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.in_instr;
            pc_q[wr_ptr]    <= bus.in_pc;
            pc4_q[wr_ptr]   <= bus.in_pc4;
        end
    end
    assign bus.out_instr = bus.out_valid ? instr_q[rd_ptr] : NOP_INSN;
    assign bus.out_pc    = bus.out_valid ? pc_q[rd_ptr]    : 32'h0;
    assign bus.out_pc4   = bus.out_valid ? pc4_q[rd_ptr]   : 32'h0;
`ifdef IF_ID_PREDECODE_EN
    logic [2:0] pd_q [DEPTH];
    logic [6:0] op;
    assign op = bus.in_instr[6:0];
    always_ff @(posedge clk) begin
        if (push) pd_q[wr_ptr] <= {op == 7'b1100011, op == 7'b1101111, op == 7'b1100111};
    end
    assign bus.out_is_branch = bus.out_valid & pd_q[rd_ptr][2];
    assign bus.out_is_jal    = bus.out_valid & pd_q[rd_ptr][1];
    assign bus.out_is_jalr   = bus.out_valid & pd_q[rd_ptr][0];
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed self-checking bench for if_id_buffer (DEPTH=2)
module tb_if_id_buffer;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    if_id_if #(.DEPTH(2)) bus ();
    if_id_buffer #(.DEPTH(2), .NOP_INSN(32'h00000013)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_pc4    = pc + 32'd4;
        bus.in_instr  = pc + 32'h1000;
        bus.out_ready = ordy;
    endtask
    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        drive(1'b1, 32'h0, 1'b0);
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_instr", bus.out_instr, 32'h00000013);
        chk("rst_count", 32'(bus.count), 0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("rel_out_valid", 32'(bus.out_valid), 0);
        chk("empty_pop_count", 32'(bus.count), 0);
        chk("rel_out_pc", bus.out_pc, 0);
        drive(1'b1, 32'h0, 1'b1);
        bus.in_instr = 32'h00500093;
        tick();
        bus.in_valid = 1'b0;
        chk("pass_out_valid", 32'(bus.out_valid), 1);
        chk("pass_out_instr", bus.out_instr, 32'h00500093);
        chk("pass_out_pc4", bus.out_pc4, 4);
        tick();
        chk("pass_drain_count", 32'(bus.count), 0);
        chk("pass_empty_instr", bus.out_instr, 32'h00000013);
        drive(1'b1, 32'h0, 1'b0);
        tick();
        chk("bp_count1", 32'(bus.count), 1);
        drive(1'b1, 32'h4, 1'b0);
        tick();
        chk("bp_count2", 32'(bus.count), 2);
        chk("bp_in_ready", 32'(bus.in_ready), 0);
        drive(1'b1, 32'h8, 1'b0);
        tick();
        chk("bp_full_count", 32'(bus.count), 2);
        chk("bp_head0", bus.out_pc, 32'h0);
        drive(1'b0, 32'h8, 1'b1);
        tick();
        chk("bp_head4", bus.out_pc, 32'h4);
        chk("bp_head4_pc4", bus.out_pc4, 32'h8);
        chk("bp_ready_back", 32'(bus.in_ready), 1);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 0);
        drive(1'b1, 32'h100, 1'b0);
        tick();
        chk("st_count_init", 32'(bus.count), 1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h104 + 32'(4 * i), 1'b1);
            tick();
            chk("st_count", 32'(bus.count), 1);
            chk("st_pc", bus.out_pc, 32'h104 + 32'(4 * i));
            chk("st_instr", bus.out_instr, 32'h1104 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("st_drain", 32'(bus.count), 0);
        drive(1'b1, 32'h200, 1'b0);
        tick();
        drive(1'b1, 32'h204, 1'b0);
        tick();
        chk("fl_pre_count", 32'(bus.count), 2);
        drive(1'b1, 32'h208, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_count", 32'(bus.count), 0);
        chk("fl_out_valid", 32'(bus.out_valid), 0);
        chk("fl_in_ready", 32'(bus.in_ready), 1);
        drive(1'b1, 32'h40, 1'b0);
        tick();
        chk("fl_new_pc", bus.out_pc, 32'h40);
        chk("fl_new_count", 32'(bus.count), 1);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("fl_no_ghost", 32'(bus.out_valid), 0);
        drive(1'b1, 32'h300, 1'b0);
        tick();
        drive(1'b1, 32'h304, 1'b0);
        tick();
        drive(1'b1, 32'h308, 1'b1);
        tick();
        chk("full_pop_count", 32'(bus.count), 1);
        chk("full_pop_head", bus.out_pc, 32'h304);
        drive(1'b1, 32'h30C, 1'b0);
        tick();
        chk("ar_pre_count", 32'(bus.count), 2);
        drive(1'b0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid), 0);
        chk("ar_count", 32'(bus.count), 0);
        chk("ar_in_ready", 32'(bus.in_ready), 1);
        #1 rst = 1'b0;
        tick();
        chk("ar_after", 32'(bus.out_valid), 0);
`ifdef IF_ID_PREDECODE_EN
        drive(1'b1, 32'h0, 1'b0);
        bus.in_instr = 32'h0000006F;
        tick();
        bus.in_valid = 1'b0;
        chk("pd_jal", 32'(bus.out_is_jal), 1);
        chk("pd_branch", 32'(bus.out_is_branch), 0);
        chk("pd_jalr", 32'(bus.out_is_jalr), 0);
        bus.out_ready = 1'b1;
        tick();
        chk("pd_empty_jal", 32'(bus.out_is_jal), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
